fir_input_buffer: RTL
=====================

FIR_INPUT_BUFFER -- requirements
Module: fir_input_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_data, input, DATA_WIDTH bits: upstream sample.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream sample present.
REQ-007 SHALL have port s_ready, output, 1 bit: buffer can accept a sample.
REQ-008 SHALL have port fir_data, output, DATA_WIDTH bits: sample presented to the FIR stage.
REQ-009 SHALL have port inputValid, output, 1 bit: one-cycle start pulse to the FIR controller.
REQ-010 SHALL have port outputValid, input, 1 bit: FIR controller done pulse.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped push.

Function
REQ-013 SHALL implement a circular FIFO with DEPTH entries.
- Read pointer and write pointer are each log2(DEPTH) bits and wrap modulo DEPTH.
- count is a separate register, range 0..DEPTH.
REQ-014 SHALL drive s_ready = (count != DEPTH), decoded combinationally from registered count only.
REQ-015 SHALL push on an edge where s_valid && s_ready: write s_data at wptr, increment wptr.
REQ-016 SHALL drop a sample on an edge where s_valid && !s_ready, and set overflow to 1 on that edge.
- Nothing is written; pointers and count are unchanged.
- overflow stays 1 until reset.
- A pop on the same edge does not make room for this push.
REQ-017 SHALL run a dispatch FSM with states IDLE, ISSUE, BUSY.
REQ-018 IDLE -> ISSUE when count != 0; otherwise remain in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle, with inputValid=1 only in ISSUE; ISSUE -> BUSY unconditionally.
REQ-020 BUSY -> IDLE on an edge where outputValid=1, and that edge pops the head (rptr+1).
REQ-021 SHALL ignore outputValid in IDLE and ISSUE; no pop, no state change.
REQ-022 SHALL drive fir_data = mem[rptr] combinationally, so it is stable from ISSUE through the end of BUSY.
REQ-023 SHALL update count on each edge as follows:
- push only: +1.
- pop only: -1.
- push and pop on the same edge: unchanged; both pointers advance.
REQ-024 SHALL give a latency from a push into an empty idle buffer at edge k to inputValid high in the cycle after edge k+1.
REQ-025 SHALL dispatch back-to-back samples with a minimum gap of one IDLE cycle between a BUSY exit and the next ISSUE.
REQ-026 SHALL never pop when count=0, even if outputValid=1.

Reset
REQ-027 While rst=0 the block SHALL immediately force:
- state IDLE, rptr=0, wptr=0, count=0;
- overflow=0, inputValid=0, s_ready=1.
REQ-028 Reset asserted mid-BUSY SHALL abandon the in-flight sample; FIFO contents are not cleared but are unreachable.
REQ-029 After rst deassertion the first push SHALL be accepted on the first rising edge.

Verification
REQ-030 The bench SHALL cover this single sample case:
- Stimulus: push 0x1234 into an empty buffer at edge 1.
- Response: inputValid high for exactly the cycle after edge 2 with fir_data=0x1234; count=1 until outputValid is pulsed, then count=0 and state IDLE.
REQ-031 The bench SHALL cover this fill/overflow case, with DEPTH=8 and outputValid never pulsed:
- Stimulus: push 9 samples.
- Response: count=8, s_ready=0, 9th sample dropped, overflow=1.
- Then pulse outputValid once: count=7 and s_ready=1.
REQ-032 The bench SHALL cover this wrap-around case:
- Stimulus: stream 20 samples 0..19 with the FIR done pulse returned 64 cycles after each inputValid.
- Response: fir_data sequence equals 0..19 in order, no drops, overflow=0.
REQ-033 The bench SHALL cover this simultaneous push/pop case:
- Stimulus: count=3 and BUSY, with a push and outputValid on the same edge.
- Response: count stays 3 and the next ISSUE presents the former second entry.
REQ-034 The bench SHALL cover this spurious done case:
- Stimulus: outputValid pulsed in IDLE with count=0, then in ISSUE with count=2.
- Response: no pop, count unchanged, no state change.
REQ-035 The bench SHALL cover this reset mid-operation case:
- Stimulus: rst low asynchronously while BUSY with count=5.
- Response: immediately count=0, inputValid=0, overflow=0, state IDLE; the next push is dispatched normally.

Source files
------------

// File: rtl/fir_input_buffer.sv
// Sample FIFO feeding a FIR stage: buffers upstream samples and issues them one
// at a time to the FIR controller with an ISSUE/BUSY handshake.
module fir_input_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_WIDTH-1:0]        fir_data,
    output logic                         inputValid,
    input  logic                         outputValid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   push;
    logic                   pop;
    logic                   drop;

    // Accept/drop decisions use registered occupancy only; a same-edge pop never frees room.
    always_comb begin
        push = s_valid && (count_q != FULL);
        drop = s_valid && (count_q == FULL);
        pop  = (state_q == BUSY) && outputValid && (count_q != '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; outputValid is only honoured in BUSY
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (outputValid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        inputValid = (state_q == ISSUE);
        s_ready    = (count_q != FULL);
    end

    // Pointer, occupancy and sticky overflow update
    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop;
        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; stale entries become unreachable when pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= s_data;
    end

    always_comb begin
        fir_data = mem_q[rptr_q];
        count    = count_q;
        overflow = overflow_q;
    end

endmodule
